// File: rtl/spy_pkg.sv
// spy_pkg: shared constants for the spy trace block.
//   - address space encodings carried in the top two spy_addr bits
//   - control register write-data bit positions
//   - STATUS0 field positions (16-bit layout, zero-padded above bit 15)
//   - spy_idle(): all-ones idle/undefined read value, cast down to bus width
package spy_pkg;

    localparam logic [1:0] SPY_LIVE  = 2'd0;
    localparam logic [1:0] SPY_SNAP  = 2'd1;
    localparam logic [1:0] SPY_TRACE = 2'd2;
    localparam logic [1:0] SPY_CSR   = 2'd3;

    localparam int CTL_ARM  = 15;
    localparam int CTL_WRAP = 14;
    localparam int CTL_CLR  = 13;

    localparam int ST_W      = 16;
    localparam int ST_ARMED  = 15;
    localparam int ST_WRAP   = 14;
    localparam int ST_OVF    = 13;
    localparam int ST_FULL   = 12;
    localparam int ST_EMPTY  = 11;
    localparam int ST_CH_LSB = 0;
    localparam int ST_CH_W   = 8;

    localparam int SPY_MAX_W = 256;

    function automatic logic [SPY_MAX_W-1:0] spy_idle();
        return '1;
    endfunction

endpackage

// File: rtl/spy_trace_if.sv
// spy_trace_if: PDP-11 debug-bus side of the spy trace block.
//   dbread    - read enable; spy_out idles all ones when low
//   spy_addr  - {space[1:0], ch, slice}
//   spy_rd    - one-clock read-complete pulse (pops the trace head)
//   spy_wr    - one-clock write pulse, spy_wdata - write data
//   spy_out   - read data
// master: debug bus driver; slave: spy_trace.
interface spy_trace_if #(
    parameter int AW    = 6,
    parameter int SPY_W = 16
);
    logic             dbread;
    logic [AW-1:0]    spy_addr;
    logic             spy_rd;
    logic             spy_wr;
    logic [SPY_W-1:0] spy_wdata;
    logic [SPY_W-1:0] spy_out;

    modport master (
        output dbread, spy_addr, spy_rd, spy_wr, spy_wdata,
        input  spy_out
    );

    modport slave (
        input  dbread, spy_addr, spy_rd, spy_wr, spy_wdata,
        output spy_out
    );
endinterface

// File: rtl/spy_trace_fifo.sv
// spy_trace_fifo: synchronous trace FIFO.
//   clk, reset (sync, active-low)
//   push/din    - write request and data
//   pop         - read request, ignored when empty
//   clr         - empties the FIFO and clears overflow, beats push/pop
//   wrap        - when full, 1 = overwrite oldest, 0 = drop and raise stop
//   dout        - head entry; count/full/empty/overflow status
//   stop        - combinational pulse: a push was dropped in stop-on-full mode
module spy_trace_fifo #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 16,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic             wrap,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             stop
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             we;
    logic             pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = ovf_q;
    assign dout     = mem_q[rptr_q];
    assign pop_ok   = pop & ~empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        stop    = 1'b0;
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (push && pop_ok) begin
            // When full, wptr == rptr: the head is read out this cycle and
            // its slot reused, so the write is always safe.
            we     = 1'b1;
            wptr_d = wptr_q + PW'(1);
            rptr_d = rptr_q + PW'(1);
        end else if (push && !full) begin
            we      = 1'b1;
            wptr_d  = wptr_q + PW'(1);
            count_d = count_q + CW'(1);
        end else if (push) begin
            ovf_d = 1'b1;
            if (wrap) begin
                we     = 1'b1;
                wptr_d = wptr_q + PW'(1);
                rptr_d = rptr_q + PW'(1);
            end else begin
                stop = 1'b1;
            end
        end else if (pop_ok) begin
            rptr_d  = rptr_q + PW'(1);
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/spy_trace.sv
// spy_trace: per-channel snapshot bank, single-channel trace FIFO and
// control/status register, all examined through the spy debug bus.
//   clk, reset       - clock, synchronous active-low reset
//   chan_in          - NCH channels, channel c at [c*CH_W +: CH_W]
//   state_write      - capture strobe: snapshot all channels, push traced one
//   bus (slave)      - spy debug bus: dbread, spy_addr, spy_rd, spy_wr,
//                      spy_wdata in; spy_out out (combinational)
module spy_trace
    import spy_pkg::*;
#(
    parameter int NCH   = 8,
    parameter int CH_W  = 32,
    parameter int SPY_W = 16,
    parameter int DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NCH*CH_W-1:0] chan_in,
    input  logic                state_write,
    spy_trace_if.slave          bus
);

    localparam int SLICES = CH_W / SPY_W;
    localparam int CHB    = $clog2(NCH);
    localparam int SLB    = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int AW     = 2 + CHB + SLB;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic [1:0]     space;
    logic [CHB-1:0] ch;
    logic [SLB-1:0] slice;

    assign space = bus.spy_addr[AW-1 -: 2];
    assign ch    = bus.spy_addr[SLB +: CHB];
    assign slice = bus.spy_addr[SLB-1:0];

    logic [NCH*CH_W-1:0] snap_q, snap_d;
    logic                armed_q, armed_d;
    logic                wrap_q, wrap_d;
    logic [CHB-1:0]      trace_ch_q, trace_ch_d;

    logic            ctl_wr;
    logic            fifo_clr;
    logic            fifo_push;
    logic            fifo_pop;
    logic [CH_W-1:0] fifo_din;
    logic [CH_W-1:0] fifo_dout;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_ovf;
    logic            fifo_stop;

    // Only a subset of the write data is stored; fold the rest away.
    logic unused_wdata;
    assign unused_wdata = ^bus.spy_wdata;

    assign ctl_wr    = bus.spy_wr && (space == SPY_CSR) && (ch == '0);
    assign fifo_clr  = ctl_wr && bus.spy_wdata[CTL_CLR];
    assign fifo_push = armed_q && state_write;
    // The head is consumed once its most significant slice has been read.
    assign fifo_pop  = bus.spy_rd && (space == SPY_TRACE) && (slice == SLB'(SLICES - 1));
    assign fifo_din  = chan_in[32'(trace_ch_q) * CH_W +: CH_W];

    spy_trace_fifo #(
        .WIDTH (CH_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .clr      (fifo_clr),
        .wrap     (wrap_q),
        .din      (fifo_din),
        .dout     (fifo_dout),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (fifo_ovf),
        .stop     (fifo_stop)
    );

    always_comb begin
        snap_d     = state_write ? chan_in : snap_q;
        armed_d    = armed_q;
        wrap_d     = wrap_q;
        trace_ch_d = trace_ch_q;
        if (ctl_wr) begin
            armed_d    = bus.spy_wdata[CTL_ARM];
            wrap_d     = bus.spy_wdata[CTL_WRAP];
            trace_ch_d = bus.spy_wdata[CHB-1:0];
        end else if (fifo_stop) begin
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            snap_q     <= '0;
            armed_q    <= 1'b0;
            wrap_q     <= 1'b0;
            trace_ch_q <= '0;
        end else begin
            snap_q     <= snap_d;
            armed_q    <= armed_d;
            wrap_q     <= wrap_d;
            trace_ch_q <= trace_ch_d;
        end
    end

    logic [ST_W-1:0]  status0;
    logic [CH_W-1:0]  live_word;
    logic [CH_W-1:0]  snap_word;
    logic             slice_ok;
    int unsigned      sl_base;
    logic [SPY_W-1:0] rd_data;

    always_comb begin
        status0                        = '0;
        status0[ST_ARMED]              = armed_q;
        status0[ST_WRAP]               = wrap_q;
        status0[ST_OVF]                = fifo_ovf;
        status0[ST_FULL]               = fifo_full;
        status0[ST_EMPTY]              = fifo_empty;
        status0[ST_CH_LSB +: ST_CH_W]  = ST_CH_W'(trace_ch_q);
    end

    assign live_word = chan_in[32'(ch) * CH_W +: CH_W];
    assign snap_word = snap_q[32'(ch) * CH_W +: CH_W];
    assign slice_ok  = (32'(slice) < SLICES);
    assign sl_base   = slice_ok ? 32'(slice) * SPY_W : 32'd0;

    always_comb begin
        rd_data = SPY_W'(spy_idle());
        if (bus.dbread && slice_ok) begin
            case (space)
                SPY_LIVE:  rd_data = live_word[sl_base +: SPY_W];
                SPY_SNAP:  rd_data = snap_word[sl_base +: SPY_W];
                SPY_TRACE: begin
                    if (!fifo_empty) begin
                        rd_data = fifo_dout[sl_base +: SPY_W];
                    end
                end
                default: begin
                    rd_data = '0;
                    if (slice == '0 && ch == CHB'(0)) begin
                        rd_data = SPY_W'(status0);
                    end else if (slice == '0 && ch == CHB'(1)) begin
                        rd_data = SPY_W'(fifo_count);
                    end
                end
            endcase
        end
    end

    assign bus.spy_out = rd_data;

endmodule

// File: tb/tb_spy_trace.sv
module tb_spy_trace;
    import spy_pkg::*;

    localparam int NCH   = 8;
    localparam int CH_W  = 32;
    localparam int SPY_W = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 6;

    logic                clk = 1'b0;
    logic                reset;
    logic [NCH*CH_W-1:0] chan_in;
    logic                state_write;

    spy_trace_if #(.AW(AW), .SPY_W(SPY_W)) bus ();

    spy_trace #(
        .NCH   (NCH),
        .CH_W  (CH_W),
        .SPY_W (SPY_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .chan_in     (chan_in),
        .state_write (state_write),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: snapshot array, trace queue, control fields.
    logic [31:0] m_snap [NCH];
    logic [31:0] m_q [$];
    logic        m_armed = 1'b0;
    logic        m_wrap  = 1'b0;
    logic        m_ovf   = 1'b0;
    logic [2:0]  m_ch    = 3'd0;

    function automatic logic [31:0] get_chan(int c);
        return chan_in[c*CH_W +: CH_W];
    endfunction

    task automatic set_chan(int c, logic [31:0] v);
        chan_in[c*CH_W +: CH_W] = v;
    endtask

    task automatic set_addr(logic [1:0] sp, logic [2:0] c, logic sl);
        bus.spy_addr = {sp, c, sl};
        bus.dbread   = 1'b1;
    endtask

    task automatic model_update();
        logic [1:0]  sp;
        logic [2:0]  c;
        logic        sl;
        logic        ctl_wr, clr, push, pop, stopped;
        logic [31:0] d;
        sp = bus.spy_addr[5:4];
        c  = bus.spy_addr[3:1];
        sl = bus.spy_addr[0];
        if (!reset) begin
            for (int i = 0; i < NCH; i++) m_snap[i] = '0;
            m_q.delete();
            m_armed = 1'b0;
            m_wrap  = 1'b0;
            m_ovf   = 1'b0;
            m_ch    = 3'd0;
            return;
        end
        ctl_wr  = bus.spy_wr && sp == 2'd3 && c == 3'd0;
        clr     = ctl_wr && bus.spy_wdata[13];
        push    = m_armed && state_write;
        pop     = bus.spy_rd && sp == 2'd2 && sl == 1'b1 && m_q.size() > 0;
        d       = get_chan(int'(m_ch));
        stopped = 1'b0;
        if (state_write)
            for (int i = 0; i < NCH; i++) m_snap[i] = get_chan(i);
        if (clr) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else if (push && pop) begin
            void'(m_q.pop_front());
            m_q.push_back(d);
        end else if (push) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(d);
            end else begin
                m_ovf = 1'b1;
                if (m_wrap) begin
                    void'(m_q.pop_front());
                    m_q.push_back(d);
                end else begin
                    stopped = 1'b1;
                end
            end
        end else if (pop) begin
            void'(m_q.pop_front());
        end
        if (ctl_wr) begin
            m_armed = bus.spy_wdata[15];
            m_wrap  = bus.spy_wdata[14];
            m_ch    = bus.spy_wdata[2:0];
        end else if (stopped) begin
            m_armed = 1'b0;
        end
    endtask

    function automatic logic [15:0] model_out();
        logic [1:0]  sp;
        logic [2:0]  c;
        logic        sl;
        logic [31:0] w;
        sp = bus.spy_addr[5:4];
        c  = bus.spy_addr[3:1];
        sl = bus.spy_addr[0];
        if (!bus.dbread) return 16'hFFFF;
        case (sp)
            2'd0: begin w = get_chan(int'(c)); return sl ? w[31:16] : w[15:0]; end
            2'd1: begin w = m_snap[c];         return sl ? w[31:16] : w[15:0]; end
            2'd2: begin
                if (m_q.size() == 0) return 16'hFFFF;
                w = m_q[0];
                return sl ? w[31:16] : w[15:0];
            end
            default: begin
                if (c == 3'd0 && !sl)
                    return {m_armed, m_wrap, m_ovf, (m_q.size() == DEPTH),
                            (m_q.size() == 0), 3'b000, 5'b00000, m_ch};
                if (c == 3'd1 && !sl) return 16'(m_q.size());
                return 16'h0000;
            end
        endcase
    endfunction

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        state_write    = 1'b0;
        bus.spy_rd     = 1'b0;
        bus.spy_wr     = 1'b0;
    endtask

    task automatic csr_write(logic [15:0] wd);
        set_addr(2'd3, 3'd0, 1'b0);
        bus.spy_wdata = wd;
        bus.spy_wr    = 1'b1;
        tick();
        bus.spy_wr    = 1'b0;
    endtask

    task automatic push_val(int c, logic [31:0] v);
        set_chan(c, v);
        state_write = 1'b1;
        tick();
        state_write = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        chan_in       = '0;
        idle();
        bus.spy_wdata = '0;
        set_addr(2'd0, 3'd0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        set_addr(2'd3, 3'd0, 1'b0); #1;
        total++;
        if (bus.spy_out !== 16'h0800) begin bad++; $display("FAIL reset_status0: got %h want %h", bus.spy_out, 16'h0800); end
        set_addr(2'd3, 3'd1, 1'b0); #1;
        total++;
        if (bus.spy_out !== 16'h0000) begin bad++; $display("FAIL reset_count: got %h want %h", bus.spy_out, 16'h0000); end
        set_addr(2'd1, 3'd3, 1'b1); #1;
        total++;
        if (bus.spy_out !== 16'h0000) begin bad++; $display("FAIL reset_snap: got %h want %h", bus.spy_out, 16'h0000); end
    endtask

    task automatic test_snapshot();
        push_val(2, 32'hDEADBEEF);
        set_chan(2, 32'h0);
        set_addr(2'd1, 3'd2, 1'b1); #1;
        total++;
        if (bus.spy_out !== 16'hDEAD) begin bad++; $display("FAIL snap_hi: got %h want %h", bus.spy_out, 16'hDEAD); end
        set_addr(2'd1, 3'd2, 1'b0); #1;
        total++;
        if (bus.spy_out !== 16'hBEEF) begin bad++; $display("FAIL snap_lo: got %h want %h", bus.spy_out, 16'hBEEF); end
        set_addr(2'd0, 3'd2, 1'b0); #1;
        total++;
        if (bus.spy_out !== 16'h0000) begin bad++; $display("FAIL live_lo: got %h want %h", bus.spy_out, 16'h0000); end
    endtask

    task automatic test_trace();
        csr_write(16'h8005);
        for (int i = 1; i <= 3; i++) push_val(5, 32'(i));
        set_addr(2'd3, 3'd1, 1'b0); #1;
        total++;
        if (bus.spy_out !== 16'd3) begin bad++; $display("FAIL trace_count3: got %h want %h", bus.spy_out, 16'd3); end
        set_addr(2'd2, 3'd0, 1'b0); #1;
        total++;
        if (bus.spy_out !== 16'd1) begin bad++; $display("FAIL trace_head_lo: got %h want %h", bus.spy_out, 16'd1); end
        bus.spy_rd = 1'b1; tick(); bus.spy_rd = 1'b0;
        set_addr(2'd2, 3'd0, 1'b1); #1;
        total++;
        if (bus.spy_out !== 16'd0) begin bad++; $display("FAIL trace_head_hi: got %h want %h", bus.spy_out, 16'd0); end
        bus.spy_rd = 1'b1; tick(); bus.spy_rd = 1'b0;
        set_addr(2'd3, 3'd1, 1'b0); #1;
        total++;
        if (bus.spy_out !== 16'd2) begin bad++; $display("FAIL trace_count2: got %h want %h", bus.spy_out, 16'd2); end
        set_addr(2'd2, 3'd6, 1'b0); #1;
        total++;
        if (bus.spy_out !== 16'd2) begin bad++; $display("FAIL trace_next: got %h want %h", bus.spy_out, 16'd2); end
    endtask

    task automatic test_stop_on_full();
        csr_write(16'hA005);
        for (int i = 0; i < DEPTH + 2; i++) push_val(5, 32'h100 + 32'(i));
        set_addr(2'd3, 3'd1, 1'b0); #1;
        total++;
        if (bus.spy_out !== 16'd16) begin bad++; $display("FAIL stop_count: got %h want %h", bus.spy_out, 16'd16); end
        set_addr(2'd3, 3'd0, 1'b0); #1;
        total++;
        if (bus.spy_out !== 16'h3005) begin bad++; $display("FAIL stop_status: got %h want %h", bus.spy_out, 16'h3005); end
        set_addr(2'd2, 3'd0, 1'b0); #1;
        total++;
        if (bus.spy_out !== 16'h0100) begin bad++; $display("FAIL stop_head: got %h want %h", bus.spy_out, 16'h0100); end
    endtask

    task automatic test_wrap();
        csr_write(16'hE005);
        for (int i = 1; i <= 20; i++) push_val(5, 32'(i));
        set_addr(2'd3, 3'd1, 1'b0); #1;
        total++;
        if (bus.spy_out !== 16'd16) begin bad++; $display("FAIL wrap_count: got %h want %h", bus.spy_out, 16'd16); end
        set_addr(2'd3, 3'd0, 1'b0); #1;
        total++;
        if (bus.spy_out !== 16'hF005) begin bad++; $display("FAIL wrap_status: got %h want %h", bus.spy_out, 16'hF005); end
        set_addr(2'd2, 3'd0, 1'b0); #1;
        total++;
        if (bus.spy_out !== 16'd5) begin bad++; $display("FAIL wrap_head: got %h want %h", bus.spy_out, 16'd5); end
        // Exactly full without overflow, then push+pop in one cycle.
        csr_write(16'hE005);
        for (int i = 0; i < DEPTH; i++) push_val(5, 32'h40 + 32'(i));
        set_addr(2'd2, 3'd0, 1'b1);
        set_chan(5, 32'h99);
        bus.spy_rd  = 1'b1;
        state_write = 1'b1;
        tick();
        bus.spy_rd  = 1'b0;
        state_write = 1'b0;
        set_addr(2'd3, 3'd0, 1'b0); #1;
        total++;
        if (bus.spy_out !== 16'hD005) begin bad++; $display("FAIL pushpop_status: got %h want %h", bus.spy_out, 16'hD005); end
        set_addr(2'd3, 3'd1, 1'b0); #1;
        total++;
        if (bus.spy_out !== 16'd16) begin bad++; $display("FAIL pushpop_count: got %h want %h", bus.spy_out, 16'd16); end
        set_addr(2'd2, 3'd0, 1'b0); #1;
        total++;
        if (bus.spy_out !== 16'h0041) begin bad++; $display("FAIL pushpop_head: got %h want %h", bus.spy_out, 16'h0041); end
    endtask

    task automatic test_clear();
        set_addr(2'd3, 3'd0, 1'b0);
        bus.spy_wdata = 16'hA005;
        bus.spy_wr    = 1'b1;
        set_chan(5, 32'h77);
        state_write   = 1'b1;
        tick();
        idle();
        set_addr(2'd3, 3'd0, 1'b0); #1;
        total++;
        if (bus.spy_out !== 16'h8805) begin bad++; $display("FAIL clear_status: got %h want %h", bus.spy_out, 16'h8805); end
        set_addr(2'd2, 3'd0, 1'b1); #1;
        total++;
        if (bus.spy_out !== 16'hFFFF) begin bad++; $display("FAIL clear_empty_read: got %h want %h", bus.spy_out, 16'hFFFF); end
        bus.spy_rd = 1'b1; tick(); bus.spy_rd = 1'b0;
        set_addr(2'd3, 3'd1, 1'b0); #1;
        total++;
        if (bus.spy_out !== 16'd0) begin bad++; $display("FAIL empty_pop_count: got %h want %h", bus.spy_out, 16'd0); end
        bus.dbread = 1'b0; #1;
        total++;
        if (bus.spy_out !== 16'hFFFF) begin bad++; $display("FAIL dbread_low: got %h want %h", bus.spy_out, 16'hFFFF); end
        push_val(5, 32'h11);
        push_val(5, 32'h22);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_addr(2'd3, 3'd0, 1'b0); #1;
        total++;
        if (bus.spy_out !== 16'h0800) begin bad++; $display("FAIL midreset_status: got %h want %h", bus.spy_out, 16'h0800); end
        set_addr(2'd3, 3'd1, 1'b0); #1;
        total++;
        if (bus.spy_out !== 16'd0) begin bad++; $display("FAIL midreset_count: got %h want %h", bus.spy_out, 16'd0); end
    endtask

    task automatic test_random();
        logic [15:0] exp;
        for (int n = 0; n < 800; n++) begin
            for (int c = 0; c < NCH; c++) set_chan(c, $urandom);
            state_write   = 1'($urandom_range(1));
            bus.spy_addr  = 6'($urandom);
            if ($urandom_range(3) == 0) bus.spy_addr = {2'd3, 3'($urandom_range(1)), 1'b0};
            bus.spy_rd    = 1'($urandom_range(1));
            bus.spy_wr    = ($urandom_range(7) == 0);
            bus.spy_wdata = 16'($urandom);
            bus.spy_wdata[13] = ($urandom_range(5) == 0);
            reset         = ($urandom_range(99) != 0);
            bus.dbread    = ($urandom_range(7) != 0);
            #1;
            exp = model_out();
            total++;
            if (bus.spy_out !== exp) begin
                bad++;
                $display("FAIL random_read[%0d] addr=%h: got %h want %h", n, bus.spy_addr, bus.spy_out, exp);
            end
            tick();
        end
        reset = 1'b1;
        idle();
        set_addr(2'd3, 3'd1, 1'b0); #1;
        exp = 16'(m_q.size());
        total++;
        if (bus.spy_out !== exp) begin bad++; $display("FAIL random_final_count: got %h want %h", bus.spy_out, exp); end
        set_addr(2'd3, 3'd0, 1'b0); #1;
        exp = model_out();
        total++;
        if (bus.spy_out !== exp) begin bad++; $display("FAIL random_final_status: got %h want %h", bus.spy_out, exp); end
    endtask

    initial begin
        test_reset();
        test_snapshot();
        test_trace();
        test_stop_on_full();
        test_wrap();
        test_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spy_trace.md
Name: spy_trace

Overview:
- Parametrised successor to the CADR spy examine mux.
- Generalises the single "ob from last cycle" latch to a per-channel snapshot bank across NCH channels of CH_W bits each.
- Adds a trace FIFO that records one selected channel on every state_write, plus a control/status register. All are readable, and the control register is writable, in SPY_W-bit slices by the PDP-11 debug bus.
- Sits beside the existing spy logic; its spy_out is ORed or muxed into the unibus spy read path by the top level.

Parameters:
- NCH, 8, number of monitored channels (2..256, power of two).
- CH_W, 32, channel width in bits; must be a multiple of SPY_W.
- SPY_W, 16, spy bus width.
- DEPTH, 16, trace FIFO entries (power of two, 2..32768).
- Derived localparams (not overridable):
  - SLICES = CH_W/SPY_W
  - CHB = clog2(NCH)
  - SLB = max(1, clog2(SLICES))
  - AW = 2+CHB+SLB
  - CW = clog2(DEPTH)+1

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-low; sampled on rising clk.
- chan_in, in, NCH*CH_W: channel c occupies bits [c*CH_W +: CH_W].
- state_write, in, 1: capture strobe, one per machine cycle.
- dbread, in, 1: spy read enable; when low, spy_out is all ones.
- spy_addr, in, AW: {space[1:0], ch[CHB-1:0], slice[SLB-1:0]}; slice 0 is the least significant.
- spy_rd, in, 1: one-clock read-complete pulse; drives FIFO pop.
- spy_wr, in, 1: one-clock write pulse.
- spy_wdata, in, SPY_W: write data.
- spy_out, out, SPY_W: read data.

Behaviour:
- Address spaces: 0 = live chan_in, 1 = snapshot, 2 = trace head entry, 3 = control/status.
- spy_out is combinational from spy_addr and state:
  - dbread=0 -> all ones.
  - space 0 -> chan_in[ch] slice.
  - space 1 -> snap[ch] slice.
  - space 2 -> fifo[rptr] slice, or all ones if the FIFO is empty (ch is ignored).
  - space 3, ch=0, slice=0 -> STATUS0 = {armed, wrap, overflow, full, empty, 3'b0, trace_ch zero-extended to 8 bits}, MSB-first, zero-padded at the top when SPY_W>16.
  - space 3, ch=1, slice=0 -> count zero-extended.
  - Any other space 3 address -> 0.
  - Slice indices >= SLICES -> all ones.
- Snapshot: on state_write, snap[c] <= chan_in[c] for all c. Captures regardless of armed. Visible the next cycle.
- Push: armed & state_write writes chan_in[trace_ch] at wptr.
- Pop: spy_rd & space==2 & slice==SLICES-1 & !empty; advances rptr. Popping an empty FIFO is ignored with no error.
- Push & pop in the same cycle: both pointers advance and count is unchanged. The write is allowed even when full, and overflow is not set.
- Push when full, without a same-cycle pop:
  - wrap=1: overwrite the oldest entry; wptr and rptr both advance; count stays DEPTH; overflow set (sticky).
  - wrap=0: entry dropped; overflow set; armed cleared (stop-on-full).
- Pointers wrap modulo DEPTH.
- full = (count==DEPTH); empty = (count==0).
- Control write (spy_wr & space==3 & ch==0):
  - arm <= wdata[15], wrap <= wdata[14], trace_ch <= wdata[CHB-1:0].
  - wdata[13]=1 clears the FIFO: ptrs = 0, count = 0, overflow = 0. This bit is self-clearing and not stored.
  - New values take effect the cycle after the write. A push in the write cycle uses the old armed and trace_ch.
  - A clear in the same cycle as a push or pop wins: the FIFO ends empty.
- spy_wr to any other address is ignored; spy_rd outside space 2 has no side effect.
- Latency: a pushed entry is readable in space 2 one cycle after the push; status updates one cycle after the event.
- Reset (reset==0 at clk edge), with priority over everything:
  - snap = 0; FIFO empty with ptrs = 0; count = 0.
  - armed = 0, wrap = 0, overflow = 0, trace_ch = 0.
  - FIFO storage contents need not be cleared.
  - Reset mid-trace discards all entries.

Decomposition:
- spy_pkg holds:
  - space encodings SPY_LIVE=0, SPY_SNAP=1, SPY_TRACE=2, SPY_CSR=3;
  - control bit positions CTL_ARM=15, CTL_WRAP=14, CTL_CLR=13;
  - STATUS0 field positions;
  - the all-ones idle value function.
- Sub-module spy_trace_fifo: parametrised synchronous FIFO (WIDTH, DEPTH) with push, pop, clr, wrap and stop-on-full, exporting count, full, empty, overflow and head data.

Test Plan:
- Reset low 2 cycles, then dbread=1, addr=CSR/ch0 -> spy_out=16'h0800 (empty only); ch1 -> 0; snap ch3 slice1 -> 0.
- Snapshot: chan_in[2]=32'hDEADBEEF, pulse state_write, change chan_in[2]=0 -> snap ch2 slice1=16'hDEAD, slice0=16'hBEEF; live ch2 slice0=0.
- Trace: write CSR 16'h8005 (arm, ch5), give 3 state_write pulses with chan_in[5]=1,2,3 -> count=3; read slice0 then slice1 with spy_rd -> 1,0 and count=2; head slice0 now 2.
- Stop-on-full: armed, wrap=0, DEPTH+2 pushes -> count=16, STATUS0 = 16'h3005 (overflow, full, armed cleared, ch5); head = first value.
- Wrap: CSR 16'hC005, 20 pushes of values 1..20 -> count=16, overflow=1, head=5; simultaneous push+pop at full -> count stays 16, no new overflow.
- Clear with a concurrent pop and push -> empty=1, count=0, overflow=0. dbread=0 -> spy_out=16'hFFFF. Mid-trace reset -> count=0, armed=0.
